// File: rtl/div_seq.sv
// Sequencer for DIV/DIVU in EX: a radix-2 restoring divider that runs one
// iteration per clock and stalls the pipeline until the result is ready.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;

    // Two's-complement negate; modulo 2^WIDTH, so the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed && v[WIDTH-1]);
    endfunction

    // One restoring step: shift {rem,quo} left, then trial-subtract the divisor.
    always_comb begin
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    assign last_iter = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !annul) begin
                        rem   <= '0;
                        quo   <= magnitude(opa, signed_div);
                        dvsr  <= magnitude(opb, signed_div);
                        q_neg <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_neg <= signed_div && opa[WIDTH-1];
                        cnt   <= '0;
                        if (opb == '0) begin
                            result_lo <= '0;
                            result_hi <= '0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            result_lo <= cond_neg(quo_next, q_neg);
                            result_hi <= cond_neg(rem_next, r_neg);
                            state     <= S_DONE;
                        end
                    end
                end
                // The same instruction is still in EX here, so start is ignored.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall_div = !rst && !annul && (((state == S_IDLE) && start) || (state == S_BUSY));
    assign ready     = (state == S_DONE) && !annul;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by zero,
// annul, mid-operation reset and back-to-back divides.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         signed_div = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         annul = 1'b0;
    logic         stall_div;
    logic         ready;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_ready1 = 0;
    int t_ready2 = 0;

    div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opa(opa), .opb(opb), .annul(annul), .stall_div(stall_div),
        .ready(ready), .result_lo(result_lo), .result_hi(result_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven here and outputs sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Cycle 0 presents the operands with start high; start stays high through DONE.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int lat,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                           output int t_rdy);
        next_cycle();
        start = 1'b1; signed_div = sgn; opa = a; opb = b;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                next_cycle();
                if (c == 2) begin
                    // Operand changes after the start cycle must not matter.
                    opa = ~a; opb = b + 32'd3; signed_div = ~sgn;
                end
            end
            #1;
            if (c < lat) begin
                check({tag, "_stall"}, {31'd0, stall_div}, 32'd1);
                check({tag, "_rdy_lo"}, {31'd0, ready}, 32'd0);
            end else begin
                t_rdy = cyc;
                check({tag, "_stall_done"}, {31'd0, stall_div}, 32'd0);
                check({tag, "_ready"}, {31'd0, ready}, 32'd1);
                check({tag, "_lo"}, result_lo, exp_lo);
                check({tag, "_hi"}, result_hi, exp_hi);
            end
        end
    endtask

    task automatic go_idle(input string tag, input int n, input logic [W-1:0] exp_lo,
                           input logic [W-1:0] exp_hi);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            start = 1'b0; annul = 1'b0;
            #1;
            check({tag, "_idle_stall"}, {31'd0, stall_div}, 32'd0);
            check({tag, "_idle_ready"}, {31'd0, ready}, 32'd0);
        end
        check({tag, "_hold_lo"}, result_lo, exp_lo);
        check({tag, "_hold_hi"}, result_hi, exp_hi);
    endtask

    initial begin
        int tdummy;

        // Reset with start held high: stall must stay low while rst is asserted.
        next_cycle();
        rst = 1'b1; start = 1'b1; opa = 32'd5; opb = 32'd1;
        next_cycle();
        #1;
        check("rst_stall", {31'd0, stall_div}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_lo", result_lo, 32'd0);
        check("rst_hi", result_hi, 32'd0);
        next_cycle();
        rst = 1'b0; start = 1'b0;
        #1;
        check("post_rst_stall", {31'd0, stall_div}, 32'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, tdummy);
        go_idle("u100_7", 2, 32'd14, 32'd2);

        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, tdummy);
        go_idle("s_m7_2", 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, tdummy);
        go_idle("u_m7_2", 1, 32'h7FFF_FFFC, 32'd1);

        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, tdummy);
        go_idle("s_ovf", 1, 32'h8000_0000, 32'd0);

        run_div("s_20_m3", 1'b1, 32'd20, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFA, 32'd2, tdummy);
        go_idle("s_20_m3", 1, 32'hFFFF_FFFA, 32'd2);

        run_div("u_div0", 1'b0, 32'd123, 32'd0, 1, 32'd0, 32'd0, tdummy);
        go_idle("u_div0", 1, 32'd0, 32'd0);

        run_div("u_77_5", 1'b0, 32'd77, 32'd5, 33, 32'd15, 32'd2, tdummy);
        go_idle("u_77_5", 1, 32'd15, 32'd2);

        run_div("s_div0", 1'b1, 32'hFFFF_FF85, 32'd0, 1, 32'd0, 32'd0, tdummy);
        go_idle("s_div0", 1, 32'd0, 32'd0);

        run_div("u100_7b", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, tdummy);
        go_idle("u100_7b", 1, 32'd14, 32'd2);

        // Annul at BUSY cycle 10: divide aborted, results keep 14/2.
        next_cycle();
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
        for (int c = 1; c < 10; c++) next_cycle();
        #1;
        check("ann_busy_pre", {31'd0, stall_div}, 32'd1);
        next_cycle();
        annul = 1'b1;
        #1;
        check("ann_busy_stall", {31'd0, stall_div}, 32'd0);
        check("ann_busy_ready", {31'd0, ready}, 32'd0);
        go_idle("ann_busy", 40, 32'd14, 32'd2);

        // Annul together with start in IDLE: nothing begins.
        next_cycle();
        start = 1'b1; annul = 1'b1; opa = 32'd9; opb = 32'd2;
        #1;
        check("ann_idle_stall", {31'd0, stall_div}, 32'd0);
        go_idle("ann_idle", 40, 32'd14, 32'd2);

        // Reset at cycle 20 of an in-flight divide.
        next_cycle();
        start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
        for (int c = 1; c < 20; c++) next_cycle();
        #1;
        check("rst_mid_pre", {31'd0, stall_div}, 32'd1);
        next_cycle();
        rst = 1'b1;
        #1;
        check("rst_mid_stall", {31'd0, stall_div}, 32'd0);
        next_cycle();
        rst = 1'b0; start = 1'b0;
        #1;
        check("rst_mid_lo", result_lo, 32'd0);
        check("rst_mid_hi", result_hi, 32'd0);
        check("rst_mid_ready", {31'd0, ready}, 32'd0);
        check("rst_mid_stall2", {31'd0, stall_div}, 32'd0);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, tdummy);
        go_idle("u9_3", 1, 32'd3, 32'd0);

        // Back-to-back: second start presented the cycle after DONE.
        run_div("b2b_1", 1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0, t_ready1);
        run_div("b2b_2", 1'b0, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF, 32'd15, t_ready2);
        check("b2b_spacing", t_ready2 - t_ready1, 32'd34);
        go_idle("b2b", 2, 32'h0FFF_FFFF, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for DIV/DIVU in the EX stage; runs a radix-2 restoring divider over 32 iterations.
- Raises a pipeline stall request while the divide is in flight.
- Presents quotient (LO) and remainder (HI) for the HILO write in the cycle the stall releases.
- Sits beside the ALU; driven by the decoded divide alucontrol plus the flush/exception annul from the hazard unit.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a valid DIV/DIVU; level, held by the stalled pipeline.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opa  in  WIDTH  dividend (rs); sampled with start.
- opb  in  WIDTH  divisor (rt); sampled with start.
- annul  in  1  flush/exception kill of the EX instruction.
- stall_div  out  1  pipeline stall request.
- ready  out  1  result valid pulse, one cycle.
- result_lo  out  WIDTH  quotient.
- result_hi  out  WIDTH  remainder.

Behaviour:
- States: IDLE, BUSY, DONE. Encoding is free.
- Reset (rst=1 at a clock edge, from any state including mid-operation):
  - state goes to IDLE; counter cleared.
  - internal partial remainder and quotient registers cleared.
  - result_lo and result_hi go to 0; ready goes to 0.
  - While rst=1, stall_div=0.
- IDLE:
  - start=1 and annul=0: latch |opa| and |opb| (absolute values only when signed_div=1), the quotient sign (sign(opa) xor sign(opb)) and the remainder sign (sign(opa)).
  - If opb==0, go to DONE.
  - Otherwise clear the counter and go to BUSY.
- BUSY:
  - One iteration per cycle: shift {rem,quo} left by 1, then form a WIDTH+1-bit trial subtract rem - divisor.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - The counter increments each cycle. After the WIDTH-th iteration (counter == WIDTH-1), go to DONE.
- DONE:
  - ready=1 for exactly this cycle; result_lo and result_hi are registered and valid in this cycle.
  - Unconditionally return to IDLE. start is ignored in DONE, because the same instruction is still in EX.
- stall_div is combinational:
  - stall_div = !rst && !annul && ((IDLE && start) || BUSY).
  - It is low in DONE, so EX advances at the end of the DONE cycle and captures the result into HILO.
- Latency: start seen at cycle 0, BUSY for cycles 1..WIDTH, DONE at cycle WIDTH+1 (33 cycles of stall for WIDTH=32).
- Sign fix-up, applied when loading the result registers on entry to DONE:
  - Negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
  - Arithmetic is modulo 2^WIDTH, so signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (opb==0):
  - Go IDLE to DONE directly; ready asserts at cycle 1.
  - result_lo=0 and result_hi=0 in both signed and unsigned modes.
- Annul:
  - Takes priority over start in IDLE: no operation begins.
  - In BUSY or DONE: go to IDLE next edge, ready is forced to 0 that cycle, and result registers keep their prior values.
- Result registers hold their value from DONE until the next DONE; they are not cleared on start.
- Back-to-back divides:
  - A second divide arriving in EX the cycle after DONE sees IDLE and starts normally.
  - No idle bubble is required beyond the DONE cycle.
- opa/opb/signed_div changes during BUSY have no effect; operands are latched.

Test Plan:
- Unsigned 100/7:
  - stall_div high for cycles 0..32 and low at 33.
  - ready=1 only at cycle 33 with lo=14, hi=2.
- Signed -7/2 (opa=0xFFFFFFF9, opb=2): at ready, lo=0xFFFFFFFD, hi=0xFFFFFFFF. The same operands with DIVU give lo=0x7FFFFFFC, hi=1.
- Overflow and zero divisor:
  - Signed 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0 at cycle 33.
  - Any opb=0 gives ready at cycle 1 with lo=hi=0 and stall_div high only in cycle 0.
- Annul:
  - Pulse annul at cycle 10 of BUSY: stall_div low that cycle, state returns to IDLE, ready never asserts, prior result values unchanged.
  - annul together with start in IDLE: stall_div stays 0 and no operation begins.
- Reset mid-operation: assert rst at cycle 20 → next cycle all outputs are 0 and state is IDLE; a fresh 9/3 then completes normally with lo=3, hi=0.
- Back-to-back: 50/5 then 0xFFFFFFFF/16 (unsigned), the second start held high from the cycle after DONE → results lo=10, hi=0 and then lo=0x0FFFFFFF, hi=15, with ready pulses 34 cycles apart.
